// File: rtl/bsg_mul_iterative_early_term.sv
`default_nettype none
// =============================================================================
// Module   : bsg_mul_iterative_early_term
// Brief    : Iterative carry-save multiplier that retires iter_step_p multiplier
//            bits per cycle and exits early on a sign-extension-only tail.
// Revision : 1.0
// =============================================================================

module bsg_mul_iterative_early_term #(
   parameter int width_p      = 32,
   parameter int iter_step_p  = 8,
   parameter int full_sized_p = 1,
   parameter int early_term_p = 1
) (
   input  logic                                          clk_i,
   input  logic                                          reset_i,
   input  logic                                          v_i,
   output logic                                          ready_o,
   input  logic [width_p-1:0]                            opA_i,
   input  logic                                          opA_is_signed_i,
   input  logic [width_p-1:0]                            opB_i,
   input  logic                                          opB_is_signed_i,
   output logic                                          v_o,
   output logic [(full_sized_p ? 2*width_p : width_p)-1:0] result_o,
   input  logic                                          yumi_i
);

   localparam int c_res_w = full_sized_p ? 2*width_p : width_p;
   localparam int c_n     = width_p / iter_step_p;
   localparam int c_cnt_w = $clog2(c_n + 1);

   typedef enum logic [1:0] {
      eIDLE = 2'd0,
      eCAL  = 2'd1,
      eCPA  = 2'd2,
      eDONE = 2'd3
   } state_e;

   state_e               r_state;
   logic [width_p-1:0]   r_a;
   logic [width_p-1:0]   r_b;
   logic [width_p-1:0]   r_lo;
   logic                 r_a_sgn;
   logic                 r_e;
   logic                 r_cin;
   logic                 r_ready;
   logic                 r_v;
   logic [c_res_w-1:0]   r_sum;
   logic [c_res_w-1:0]   r_carry;
   logic [c_res_w-1:0]   r_result;
   logic [c_cnt_w-1:0]   r_iter;

   logic [c_res_w-1:0]   w_a_ext;
   logic [c_res_w-1:0]   w_s;
   logic [c_res_w-1:0]   w_c;
   logic [c_res_w-1:0]   w_x;
   logic [c_res_w-1:0]   w_t;
   logic [c_res_w-1:0]   w_hi;
   logic [width_p-1:0]   w_b_next;
   logic [iter_step_p:0] w_low;
   logic                 w_last;
   logic                 w_exit;
   logic                 w_neg;

   // Accumulator is kept modulo 2^c_res_w in a frame that slides up by
   // iter_step_p each cycle; any wrap error lands above the result width.
   always_comb begin
      w_a_ext  = r_a_sgn ? c_res_w'($signed(r_a)) : c_res_w'(r_a);
      w_b_next = width_p'({{width_p{r_e}}, r_b} >> iter_step_p);
      w_last   = (r_iter == c_cnt_w'(c_n - 1));
      w_exit   = w_last || ((early_term_p != 0) && (w_b_next == {width_p{r_e}}));
      w_neg    = w_exit && r_e;

      w_s = r_sum;
      w_c = r_carry;
      w_x = '0;
      w_t = '0;
      for (int j = 0; j < iter_step_p; j++) begin
         w_x = r_b[j] ? (w_a_ext << j) : '0;
         w_t = ((w_s & w_c) | (w_s & w_x) | (w_c & w_x)) << 1;
         w_s = w_s ^ w_c ^ w_x;
         w_c = w_t;
      end

      // Negative tail: subtract opA at the exit position as ~(A<<S)+1,
      // the +1 riding in carry bit 0 which the shifted carry leaves free.
      w_x = w_neg ? ~(w_a_ext << iter_step_p) : '0;
      w_t = ((w_s & w_c) | (w_s & w_x) | (w_c & w_x)) << 1;
      w_s = w_s ^ w_c ^ w_x;
      w_c = w_t | c_res_w'(w_neg);

      w_low = {1'b0, w_s[iter_step_p-1:0]} + {1'b0, w_c[iter_step_p-1:0]}
            + (iter_step_p+1)'(r_cin);
      w_hi  = r_sum + r_carry + c_res_w'(r_cin);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= eIDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_lo     <= '0;
         r_a_sgn  <= 1'b0;
         r_e      <= 1'b0;
         r_cin    <= 1'b0;
         r_ready  <= 1'b1;
         r_v      <= 1'b0;
         r_sum    <= '0;
         r_carry  <= '0;
         r_result <= '0;
         r_iter   <= '0;
      end else begin
         case (r_state)
            eIDLE: begin
               if (v_i) begin
                  r_a     <= opA_i;
                  r_a_sgn <= opA_is_signed_i;
                  r_b     <= opB_i;
                  r_e     <= opB_i[width_p-1] & opB_is_signed_i;
                  r_sum   <= '0;
                  r_carry <= '0;
                  r_cin   <= 1'b0;
                  r_lo    <= '0;
                  r_iter  <= '0;
                  r_ready <= 1'b0;
                  r_state <= eCAL;
               end
            end
            eCAL: begin
               r_sum   <= w_s >> iter_step_p;
               r_carry <= w_c >> iter_step_p;
               r_cin   <= w_low[iter_step_p];
               r_lo    <= r_lo | (width_p'(w_low[iter_step_p-1:0]) << (32'(r_iter) * iter_step_p));
               r_b     <= w_b_next;
               r_iter  <= r_iter + c_cnt_w'(1);
               if (w_exit) begin
                  r_state <= eCPA;
               end
            end
            eCPA: begin
               r_result <= (w_hi << (32'(r_iter) * iter_step_p)) | c_res_w'(r_lo);
               r_v      <= 1'b1;
               r_state  <= eDONE;
            end
            eDONE: begin
               if (yumi_i) begin
                  r_v     <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= eIDLE;
               end
            end
            default: r_state <= eIDLE;
         endcase
      end
   end

   assign ready_o  = r_ready;
   assign v_o      = r_v;
   assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_bsg_mul_iterative_early_term.sv
`default_nettype none
// =============================================================================
// Module   : tb_bsg_mul_iterative_early_term
// Brief    : Bench for the iterative multiplier over several step/size/exit configs.
// Revision : 1.0
// =============================================================================

module tb_bsg_mul_iterative_early_term;

   localparam int c_ninst = 7;

   // Instances 0..4: steps 1,4,8,16,32 (full, early); 5: no early exit; 6: low half only.
   function automatic int inst_step(input int i);
      return (i == 0) ? 1 : (i == 1) ? 4 : (i == 3) ? 16 : (i == 4) ? 32 : 8;
   endfunction
   function automatic int inst_full(input int i);
      return (i == 6) ? 0 : 1;
   endfunction
   function automatic int inst_early(input int i);
      return (i == 5) ? 0 : 1;
   endfunction

   logic                 clk = 1'b0;
   logic                 rst;
   logic [c_ninst-1:0]   v;
   logic [c_ninst-1:0]   yumi;
   logic [c_ninst-1:0]   rdy;
   logic [c_ninst-1:0]   vo;
   logic [c_ninst-1:0]   busy;
   logic [c_ninst-1:0]   hold;
   logic [31:0]          opa [c_ninst];
   logic [31:0]          opb [c_ninst];
   logic                 asg [c_ninst];
   logic                 bsg [c_ninst];
   logic [63:0]          res [c_ninst];
   logic [63:0]          exp_res [c_ninst];
   logic [63:0]          got_res [c_ninst];
   int                   exp_lat [c_ninst];
   int                   got_lat [c_ninst];
   int                   launch [c_ninst];
   int                   cyc;
   int                   n_cmp;
   int                   n_err;
   int                   t_end;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < c_ninst; gi++) begin : g_dut
      localparam int c_step  = inst_step(gi);
      localparam int c_full  = inst_full(gi);
      localparam int c_early = inst_early(gi);
      localparam int c_r     = c_full ? 64 : 32;
      logic [c_r-1:0] w_res;
      logic           w_rdy;
      logic           w_vo;
      bsg_mul_iterative_early_term #(
         .width_p     (32),
         .iter_step_p (c_step),
         .full_sized_p(c_full),
         .early_term_p(c_early)
      ) u_dut (
         .clk_i          (clk),
         .reset_i        (rst),
         .v_i            (v[gi]),
         .ready_o        (w_rdy),
         .opA_i          (opa[gi]),
         .opA_is_signed_i(asg[gi]),
         .opB_i          (opb[gi]),
         .opB_is_signed_i(bsg[gi]),
         .v_o            (w_vo),
         .result_o       (w_res),
         .yumi_i         (yumi[gi])
      );
      assign rdy[gi] = w_rdy;
      assign vo[gi]  = w_vo;
      assign res[gi] = 64'(w_res);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Product modulo 2^64 from operands extended to 64 bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic as_,
                                           input logic [31:0] b, input logic bs_);
      logic [63:0] xa;
      logic [63:0] xb;
      xa = as_ ? {{32{a[31]}}, a} : {32'b0, a};
      xb = bs_ ? {{32{b[31]}}, b} : {32'b0, b};
      return xa * xb;
   endfunction

   function automatic int kstar(input logic [31:0] b, input logic bs_, input int step, input int early);
      int  n;
      logic e;
      bit  ok;
      n = 32 / step;
      e = b[31] & bs_;
      if (early == 0) return n;
      for (int k = 1; k <= n; k++) begin
         ok = 1'b1;
         for (int j = k * step; j < 32; j++) if (b[j] != e) ok = 1'b0;
         if (ok) return k;
      end
      return n;
   endfunction

   function automatic logic [31:0] rand_b();
      logic [31:0] x;
      int          sh;
      case ($urandom_range(0, 3))
         0: x = $urandom;
         1: x = 32'($urandom_range(0, 255));
         2: x = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
         default: begin
            x  = $urandom;
            sh = $urandom_range(0, 31);
            for (int j = sh + 1; j < 32; j++) x[j] = x[sh];
         end
      endcase
      return x;
   endfunction

   function automatic logic [31:0] rand_a();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
      v    = '0;
      yumi = '0;
      for (int i = 0; i < c_ninst; i++) begin
         if (busy[i]) begin
            if (vo[i]) begin
               got_res[i] = res[i];
               got_lat[i] = cyc - launch[i];
               chk($sformatf("res%0d", i), res[i], exp_res[i]);
               chk($sformatf("lat%0d", i), 64'(got_lat[i]), 64'(exp_lat[i]));
               busy[i] = 1'b0;
               if (!hold[i]) yumi[i] = 1'b1;
            end else if (cyc - launch[i] > 60) begin
               chk($sformatf("timeout%0d", i), 64'(vo[i]), 64'd1);
               busy[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic as_,
                        input logic [31:0] b, input logic bs_);
      opa[i]     = a;
      asg[i]     = as_;
      opb[i]     = b;
      bsg[i]     = bs_;
      v[i]       = 1'b1;
      busy[i]    = 1'b1;
      launch[i]  = cyc;
      exp_res[i] = ref_mul(a, as_, b, bs_);
      if (inst_full(i) == 0) exp_res[i][63:32] = '0;
      exp_lat[i] = kstar(b, bs_, inst_step(i), inst_early(i)) + 2;
   endtask

   task automatic run_all(input logic [31:0] a, input logic as_, input logic [31:0] b, input logic bs_);
      for (int i = 0; i < c_ninst; i++) issue(i, a, as_, b, bs_);
      for (int t = 0; t < 80 && busy != '0; t++) tick();
      tick();
      tick();
   endtask

   initial begin
      v = '0; yumi = '0; hold = '0; busy = '0;
      rst = 1'b1; cyc = 0; n_cmp = 0; n_err = 0;
      for (int i = 0; i < c_ninst; i++) begin
         opa[i] = '0; opb[i] = '0; asg[i] = 1'b0; bsg[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(rdy[2]), 64'd1);
      chk("rst_vo",    64'(vo[2]),  64'd0);
      chk("rst_res",   res[2],      64'd0);
      rst = 1'b0;
      tick();

      run_all(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
      chk("uu_ff_res", got_res[2], 64'hFFFF_FFFE_0000_0001);
      chk("uu_ff_lat", 64'(got_lat[2]), 64'd6);

      run_all(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
      chk("ss_m1_res",    got_res[2], 64'h1);
      chk("ss_m1_lat",    64'(got_lat[2]), 64'd3);
      chk("ss_m1_et0_res", got_res[5], 64'h1);
      chk("ss_m1_et0_lat", 64'(got_lat[5]), 64'd6);

      run_all(32'h8000_0000, 1'b1, 32'h0000_0002, 1'b0);
      chk("su_min_res",     got_res[2], 64'hFFFF_FFFF_0000_0000);
      chk("su_min_lat",     64'(got_lat[2]), 64'd3);
      chk("su_min_fs0_res", got_res[6], 64'h0);

      hold[2] = 1'b1;
      for (int i = 0; i < c_ninst; i++) issue(i, 32'h1234_5678, 1'b0, 32'h9ABC_DEF0, 1'b0);
      for (int t = 0; t < 80 && busy != '0; t++) tick();
      chk("hold_first_res", got_res[2], 64'h0B00_EA4E_242D_2080);
      chk("hold_first_lat", 64'(got_lat[2]), 64'd6);
      for (int j = 0; j < 10; j++) begin
         tick();
         chk("hold_v",   64'(vo[2]),  64'd1);
         chk("hold_res", res[2],      64'h0B00_EA4E_242D_2080);
         chk("hold_rdy", 64'(rdy[2]), 64'd0);
         opa[2] = $urandom;
         opb[2] = $urandom;
         v[2]   = j[0];
      end
      tick();
      yumi[2] = 1'b1;
      tick();
      chk("yumi_rdy", 64'(rdy[2]), 64'd1);
      chk("yumi_vo",  64'(vo[2]),  64'd0);
      hold[2] = 1'b0;
      tick();

      for (int i = 0; i < c_ninst; i++) issue(i, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
      tick();
      tick();
      rst  = 1'b1;
      busy = '0;
      tick();
      chk("abort_rdy", 64'(rdy[2]), 64'd1);
      chk("abort_vo",  64'(vo[2]),  64'd0);
      chk("abort_res", res[2],      64'd0);
      rst = 1'b0;
      for (int j = 0; j < 12; j++) begin
         tick();
         chk("abort_no_v", 64'(vo), 64'd0);
      end

      run_all(32'h0000_1000, 1'b0, 32'h0000_0003, 1'b0);
      chk("post_rst_res", got_res[2], 64'h3000);
      chk("post_rst_lat", 64'(got_lat[2]), 64'd3);

      t_end = cyc + 25000;
      while (cyc < t_end) begin
         tick();
         for (int i = 0; i < c_ninst; i++) begin
            if (!busy[i] && rdy[i]) begin
               issue(i, rand_a(), 1'($urandom_range(0, 1)), rand_b(), 1'($urandom_range(0, 1)));
            end
         end
      end
      for (int t = 0; t < 80 && busy != '0; t++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
